// File: rtl/imm_splitter_if.sv
// Handshake bundle for imm_splitter: word input side and chunk output side.
interface imm_splitter_if #(
  parameter int unsigned N     = 16,
  parameter int unsigned CHUNK = 4
);
  localparam int unsigned CW = $clog2(N / CHUNK) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [CHUNK-1:0] out_chunk;
  logic             out_first;
  logic             out_last;
  logic [CW-1:0]    out_count;

  // Producer of words / consumer of chunks
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_chunk, out_first, out_last, out_count
  );

  // The splitter itself
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_chunk, out_first, out_last, out_count
  );
endinterface

// File: rtl/imm_splitter.sv
// Splits a signed N-bit word into the fewest CHUNK-bit pieces that rebuild it
// through a sign-extend-then-shift-in decoder, streaming chunks MS-first.
module imm_splitter #(
  parameter int unsigned N     = 16,
  parameter int unsigned CHUNK = 4
) (
  input logic           clk,
  input logic           reset,
  imm_splitter_if.slave bus
);
  localparam int unsigned NCHUNK = N / CHUNK;
  localparam int unsigned CW     = $clog2(NCHUNK) + 1;

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e r_state, w_state_next;

  logic [N-1:0]     r_word,      w_word_d;
  logic [CW-1:0]    r_idx,       w_idx_d;
  logic             r_out_valid, w_out_valid_d;
  logic [CHUNK-1:0] r_out_chunk, w_out_chunk_d;
  logic             r_out_first, w_out_first_d;
  logic             r_out_last,  w_out_last_d;
  logic [CW-1:0]    r_out_count, w_out_count_d;

  logic [CW-1:0]        w_count;
  logic signed [N-1:0]  w_shifted;

  function automatic logic [CHUNK-1:0] pick(input logic [N-1:0] word, input logic [CW-1:0] idx);
    int unsigned sh;
    sh = 32'(idx) * CHUNK;
    return CHUNK'(word >> sh);
  endfunction

  // Smallest chunk count whose signed range holds in_data; the widest always fits
  always_comb begin
    w_count   = CW'(NCHUNK);
    w_shifted = '0;
    for (int k = NCHUNK - 1; k >= 1; k--) begin
      w_shifted = $signed(bus.in_data) >>> (CHUNK * k - 1);
      if (w_shifted == '0 || w_shifted == '1) w_count = CW'(k);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (bus.in_valid) w_state_next = StEmit;
      StEmit:  if (bus.out_ready && r_out_last) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Next values of the datapath and the registered outputs; default is hold
  always_comb begin
    w_word_d      = r_word;
    w_idx_d       = r_idx;
    w_out_valid_d = r_out_valid;
    w_out_chunk_d = r_out_chunk;
    w_out_first_d = r_out_first;
    w_out_last_d  = r_out_last;
    w_out_count_d = r_out_count;
    unique case (r_state)
      StIdle: begin
        if (bus.in_valid) begin
          w_word_d      = bus.in_data;
          w_idx_d       = w_count - CW'(1);
          w_out_valid_d = 1'b1;
          w_out_chunk_d = pick(bus.in_data, w_count - CW'(1));
          w_out_first_d = 1'b1;
          w_out_last_d  = (w_count == CW'(1));
          w_out_count_d = w_count;
        end
      end
      StEmit: begin
        if (bus.out_ready) begin
          if (r_out_last) begin
            w_idx_d       = '0;
            w_out_valid_d = 1'b0;
            w_out_chunk_d = '0;
            w_out_first_d = 1'b0;
            w_out_last_d  = 1'b0;
            w_out_count_d = '0;
          end else begin
            w_idx_d       = r_idx - CW'(1);
            w_out_chunk_d = pick(r_word, r_idx - CW'(1));
            w_out_first_d = 1'b0;
            w_out_last_d  = (r_idx == CW'(1));
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_word      <= '0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_chunk <= '0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_count <= '0;
    end else begin
      r_word      <= w_word_d;
      r_idx       <= w_idx_d;
      r_out_valid <= w_out_valid_d;
      r_out_chunk <= w_out_chunk_d;
      r_out_first <= w_out_first_d;
      r_out_last  <= w_out_last_d;
      r_out_count <= w_out_count_d;
    end
  end

  assign bus.in_ready  = (r_state == StIdle);
  assign bus.out_valid = r_out_valid;
  assign bus.out_chunk = r_out_chunk;
  assign bus.out_first = r_out_first;
  assign bus.out_last  = r_out_last;
  assign bus.out_count = r_out_count;
endmodule

// File: tb/tb_imm_splitter.sv
// Bench for imm_splitter: directed corner words plus random words, checked
// against a range-based chunk model and a sign-extend decoder round trip.
module tb_imm_splitter;
  logic clk = 1'b0;
  logic reset;

  int n_compared   = 0;
  int n_mismatched = 0;

  imm_splitter_if #(.N(16), .CHUNK(4)) bus ();

  imm_splitter #(.N(16), .CHUNK(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Fewest 4-bit chunks: value must lie in the signed range of 4*k bits
  function automatic int ref_count(input logic [15:0] v);
    int s;
    s = int'($signed(v));
    for (int k = 1; k <= 4; k++) begin
      if (s >= -(1 << (4 * k - 1)) && s < (1 << (4 * k - 1))) return k;
    end
    return 4;
  endfunction

  function automatic int ref_chunk(input logic [15:0] v, input int pos);
    return (int'(v) / (1 << (4 * pos))) % 16;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".in_ready"},  int'(bus.in_ready),  1);
    check({tag, ".out_valid"}, int'(bus.out_valid), 0);
    check({tag, ".chunk"},     int'(bus.out_chunk), 0);
    check({tag, ".first"},     int'(bus.out_first), 0);
    check({tag, ".last"},      int'(bus.out_last),  0);
    check({tag, ".count"},     int'(bus.out_count), 0);
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready from pat bits (LSB = first cycle)
  // abort_after >= 0 asserts reset once that many chunks have been taken
  task automatic run_word(input logic [15:0] val, input int mode, input logic [31:0] pat,
                          input int abort_after);
    int n, j, cyc, acc;
    bit rdy;
    n = ref_count(val);
    check("accept.in_ready", int'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_data  = val;
    step();
    bus.in_valid = 1'b0;
    j   = 0;
    cyc = 0;
    acc = 0;
    while (j < n && cyc < 64) begin
      if (abort_after >= 0 && j == abort_after) begin
        bus.out_ready = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort.out_valid", int'(bus.out_valid), 0);
        check("abort.in_ready",  int'(bus.in_ready),  1);
        check("abort.chunk",     int'(bus.out_chunk), 0);
        return;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (cyc < 32) ? pat[cyc] : 1'b1;
      endcase
      bus.out_ready = rdy;
      // Traffic on the input side during EMIT must be ignored
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = 16'($urandom);
      check("emit.out_valid", int'(bus.out_valid), 1);
      check("emit.in_ready",  int'(bus.in_ready),  0);
      check("emit.chunk",     int'(bus.out_chunk), ref_chunk(val, n - 1 - j));
      check("emit.first",     int'(bus.out_first), int'(j == 0));
      check("emit.last",      int'(bus.out_last),  int'(j == n - 1));
      check("emit.count",     int'(bus.out_count), n);
      if (rdy) begin
        if (j == 0) acc = (int'(bus.out_chunk) >= 8) ? int'(bus.out_chunk) - 16
                                                     : int'(bus.out_chunk);
        else        acc = acc * 16 + int'(bus.out_chunk);
        j++;
      end
      step();
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("drain.chunks", j, n);
    check("roundtrip", acc, int'($signed(val)));
    check_idle("after");
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    check_idle("reset");

    run_word(16'h0005, 0, 0, -1);
    run_word(16'hFFF8, 0, 0, -1);
    run_word(16'h0008, 0, 0, -1);
    run_word(16'hFF7F, 0, 0, -1);
    run_word(16'h1234, 2, 32'b1011001, -1);
    run_word(16'h8000, 0, 0, -1);
    run_word(16'h7FFF, 1, 0, -1);
    run_word(16'hFFFF, 0, 0, -1);
    run_word(16'h0000, 0, 0, -1);
    run_word(16'h1234, 0, 0, 2);
    run_word(16'h0003, 0, 0, -1);

    for (int i = 0; i < 1500; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       v = {{12{v[3]}}, v[3:0]};
        1:       v = {{8{v[7]}}, v[7:0]};
        2:       v = {{4{v[11]}}, v[11:0]};
        default: ;
      endcase
      run_word(v, int'($urandom_range(0, 1)), 0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
